eth_header_stream_parser: RTL

Streaming Ethernet header parser that extracts destination MAC, source MAC and EtherType from a byte-lane AXI-Stream-style frame input of configurable width. Optionally extracts one 802.1Q VLAN tag. It sits directly behind the MAC receive interface. It emits one registered header record per frame on a valid/ready output and discards the payload. It also flags frames that end before the header is complete.

---
 rtl/eth_parser_pkg.sv | 27 ++
 rtl/eth_hdr_byte_capture.sv | 49 ++++
 rtl/eth_header_stream_parser.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/eth_parser_pkg.sv
// Shared types and constants for the Ethernet header stream parser.
// Optional 802.1Q support is selected with the ETH_VLAN_EN macro in the
// files that import this package.
package eth_parser_pkg;

  typedef logic [47:0] mac_addr_t;
  typedef logic [15:0] ethertype_t;

  localparam int         ETH_HDR_LEN      = 14;
  localparam int         ETH_VLAN_HDR_LEN = 18;
  localparam ethertype_t ETHERTYPE_VLAN   = 16'h8100;

  typedef enum logic {
    ST_HDR  = 1'b0,
    ST_SKIP = 1'b1
  } parse_state_t;

  typedef struct packed {
    mac_addr_t  dest_mac;
    mac_addr_t  src_mac;
    ethertype_t ethertype;
    logic       vlan_present;
    logic [15:0] vlan_tci;
    logic       hdr_err;
  } eth_hdr_rec_t;

endpackage

// File: rtl/eth_hdr_byte_capture.sv
// Header byte capture: places each valid input lane at its absolute frame
// offset inside a CAP_BYTES-deep byte register. cap_next is the merged view
// (stored bytes plus this beat's lanes) so the record can be built on the
// same beat that completes the header. The stored image is cleared at frame
// start so bytes that never arrive read as zero.
module eth_hdr_byte_capture
  import eth_parser_pkg::*;
#(
  parameter int DATA_BYTES = 8,
  parameter int CAP_BYTES  = ETH_HDR_LEN,
  parameter int BCNT_W     = 6
) (
  input  logic                           clk,
  input  logic                           cap_en,
  input  logic                           frame_start,
  input  logic [BCNT_W-1:0]              bcnt,
  input  logic [DATA_BYTES*8-1:0]        s_tdata,
  input  logic [DATA_BYTES-1:0]          s_tkeep,
  output logic [CAP_BYTES-1:0][7:0]      cap_next
);

  localparam int IW = $clog2(CAP_BYTES);
  localparam int OW = BCNT_W + 1;

  logic [CAP_BYTES-1:0][7:0]  cap_q;
  logic [DATA_BYTES-1:0][OW-1:0] lane_off;

  for (genvar i = 0; i < DATA_BYTES; i++) begin : g_lane_off
    assign lane_off[i] = OW'(bcnt) + OW'(i);
  end

  // Merge lanes that fall inside the header window into the byte image
  always_comb begin
    cap_next = frame_start ? '0 : cap_q;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (s_tkeep[i] && (lane_off[i] < OW'(CAP_BYTES))) begin
        cap_next[lane_off[i][IW-1:0]] = s_tdata[8*i +: 8];
      end
    end
  end

  // Store the merged image on every header beat that is accepted
  always_ff @(posedge clk) begin
    if (cap_en) begin
      cap_q <= cap_next;
    end
  end

endmodule

// File: rtl/eth_header_stream_parser.sv
// Streaming Ethernet header parser. Extracts destination/source MAC and
// EtherType from a byte-lane stream, emits one registered record per frame on
// a valid/ready port, drops the payload and flags runt frames.
// Define ETH_VLAN_EN to decode a single 802.1Q tag (18-byte header when
// tagged, ethertype reports the inner type).
module eth_header_stream_parser
  import eth_parser_pkg::*;
#(
  parameter int DATA_BYTES = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_BYTES*8-1:0] s_tdata,
  input  logic [DATA_BYTES-1:0]   s_tkeep,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic                    hdr_valid,
  input  logic                    hdr_ready,
  output mac_addr_t               dest_mac,
  output mac_addr_t               src_mac,
  output ethertype_t              ethertype,
  output logic                    vlan_present,
  output logic [15:0]             vlan_tci,
  output logic                    hdr_err
);

  if (DATA_BYTES != 1 && DATA_BYTES != 2 && DATA_BYTES != 4 &&
      DATA_BYTES != 8 && DATA_BYTES != 16) begin : g_bad_data_bytes
    $error("eth_header_stream_parser: DATA_BYTES must be 1, 2, 4, 8 or 16");
  end

`ifdef ETH_VLAN_EN
  localparam int CAP_BYTES = ETH_VLAN_HDR_LEN;
`else
  localparam int CAP_BYTES = ETH_HDR_LEN;
`endif
  localparam int BCNT_W = 6;
  localparam int CW     = BCNT_W + 1;
  localparam logic [CW-1:0] LEN_STD  = CW'(ETH_HDR_LEN);
  localparam logic [CW-1:0] LEN_VLAN = CW'(ETH_VLAN_HDR_LEN);
  localparam logic [CW-1:0] LANES    = CW'(DATA_BYTES);

  parse_state_t             state_q;
  logic [BCNT_W-1:0]        bcnt_q;
  logic                     hdr_valid_q;
  eth_hdr_rec_t             rec_q;

  logic                     beat_acc;
  logic                     frame_start;
  logic                     cap_en;
  logic [CW-1:0]            bcnt_sum;
  logic [CW-1:0]            req_len;
  logic [CW-1:0]            bcnt_lim;
  logic [BCNT_W-1:0]        bcnt_sat;
  logic                     hdr_done;
  logic                     is_vlan;
  logic [CAP_BYTES-1:0][7:0] cap_next;
  eth_hdr_rec_t             rec_next;

  function automatic logic [CW-1:0] keep_count(input logic [DATA_BYTES-1:0] k);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      n = n + CW'(k[i]);
    end
    return n;
  endfunction

  eth_hdr_byte_capture #(
    .DATA_BYTES (DATA_BYTES),
    .CAP_BYTES  (CAP_BYTES),
    .BCNT_W     (BCNT_W)
  ) u_capture (
    .clk         (clk),
    .cap_en      (cap_en),
    .frame_start (frame_start),
    .bcnt        (bcnt_q),
    .s_tdata     (s_tdata),
    .s_tkeep     (s_tkeep),
    .cap_next    (cap_next)
  );

  // A header beat may only land when the output slot is free or draining
  assign s_tready    = (state_q == ST_SKIP) || !hdr_valid_q || hdr_ready;
  assign beat_acc    = s_tvalid && s_tready;
  assign frame_start = (state_q == ST_HDR) && (bcnt_q == '0);
  assign cap_en      = beat_acc && (state_q == ST_HDR);

  // Header length tracking and record assembly from the merged byte image
  always_comb begin
    bcnt_sum = CW'(bcnt_q) + keep_count(s_tkeep);
`ifdef ETH_VLAN_EN
    // The tag decision needs bytes 12..13 actually present, not zero-filled
    is_vlan = (bcnt_sum >= LEN_STD) &&
              ({cap_next[12], cap_next[13]} == ETHERTYPE_VLAN);
`else
    is_vlan = 1'b0;
`endif
    req_len  = is_vlan ? LEN_VLAN : LEN_STD;
    hdr_done = (bcnt_sum >= req_len);
    bcnt_lim = req_len + LANES;
    bcnt_sat = (bcnt_sum > bcnt_lim) ? bcnt_lim[BCNT_W-1:0] : bcnt_sum[BCNT_W-1:0];

    rec_next = '0;
    for (int j = 0; j < 6; j++) begin
      rec_next.dest_mac[8*j +: 8] = cap_next[j];
      rec_next.src_mac[8*j +: 8]  = cap_next[6+j];
    end
`ifdef ETH_VLAN_EN
    rec_next.vlan_present = is_vlan;
    rec_next.vlan_tci     = is_vlan ? {cap_next[14], cap_next[15]} : 16'h0000;
    rec_next.ethertype    = is_vlan ? {cap_next[16], cap_next[17]}
                                    : {cap_next[12], cap_next[13]};
`else
    rec_next.ethertype    = {cap_next[12], cap_next[13]};
`endif
    rec_next.hdr_err      = !hdr_done;
  end

  // Parser FSM: header capture, payload skip, record load and handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HDR;
      bcnt_q      <= '0;
      hdr_valid_q <= 1'b0;
      rec_q       <= '0;
    end else begin
      if (hdr_valid_q && hdr_ready) begin
        hdr_valid_q <= 1'b0;
      end
      if (beat_acc) begin
        case (state_q)
          ST_HDR: begin
            if (hdr_done || s_tlast) begin
              rec_q       <= rec_next;
              hdr_valid_q <= 1'b1;
              if (s_tlast) begin
                state_q <= ST_HDR;
                bcnt_q  <= '0;
              end else begin
                state_q <= ST_SKIP;
                bcnt_q  <= bcnt_sat;
              end
            end else begin
              bcnt_q <= bcnt_sat;
            end
          end
          ST_SKIP: begin
            if (s_tlast) begin
              state_q <= ST_HDR;
              bcnt_q  <= '0;
            end else begin
              bcnt_q  <= bcnt_sat;
            end
          end
          default: begin
            state_q <= ST_HDR;
            bcnt_q  <= '0;
          end
        endcase
      end
    end
  end

  assign hdr_valid    = hdr_valid_q;
  assign dest_mac     = rec_q.dest_mac;
  assign src_mac      = rec_q.src_mac;
  assign ethertype    = rec_q.ethertype;
  assign vlan_present = rec_q.vlan_present;
  assign vlan_tci     = rec_q.vlan_tci;
  assign hdr_err      = rec_q.hdr_err;

endmodule
